decode_stage_pipe: RTL and testbench

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

---
 rtl/decode_pkg.sv | 132 +++++++++++++
 rtl/decode_stage_pipe_regfile.sv | 62 ++++++
 rtl/decode_stage_pipe.sv | 125 ++++++++++++
 tb/tb_decode_stage_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the decode stage: control-word width,
//               control-bit positions, opcodes, the bubble word and the
//               Control decoder function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

  // Control word layout, MSB first
  localparam int CTRL_W            = 15;
  localparam int CTRL_REGDST       = 14;
  localparam int CTRL_BRANCHNE     = 13;
  localparam int CTRL_BRANCHEQ     = 12;
  localparam int CTRL_ALUOP_HI     = 11;
  localparam int CTRL_ALUOP_LO     = 9;
  localparam int CTRL_ALUSRC       = 8;
  localparam int CTRL_REGWRITE     = 7;
  localparam int CTRL_MEMWRITE     = 6;
  localparam int CTRL_MEMREAD      = 5;
  localparam int CTRL_MEMTOREG     = 4;
  localparam int CTRL_SHAMTSEL     = 3;
  localparam int CTRL_REGISTERORPC = 2;
  localparam int CTRL_ALUMEMORPC   = 1;
  localparam int CTRL_JUMPCONTROL  = 0;

  // Control word loaded into the ID/EX register for an empty slot
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // ALU operation classes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes with special control
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;

  // Control decoder: opcode/funct to packed control word; unknown opcodes decode to all-zero
  function automatic logic [CTRL_W-1:0] control_decode(input logic [5:0] opcode,
                                                        input logic [5:0] funct);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c[CTRL_REGDST]                 = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALU_RTYPE;
        c[CTRL_REGWRITE]               = 1'b1;
        if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA) begin
          c[CTRL_SHAMTSEL] = 1'b1;
        end
        if (funct == FN_JR) begin
          c[CTRL_REGWRITE]     = 1'b0;
          c[CTRL_REGISTERORPC] = 1'b1;
          c[CTRL_JUMPCONTROL]  = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALU_ADD;
      end
      OP_SLTI: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALU_SLT;
      end
      OP_ANDI: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALU_AND;
      end
      OP_ORI: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALU_OR;
      end
      OP_LW: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_MEMREAD]  = 1'b1;
        c[CTRL_MEMTOREG] = 1'b1;
      end
      OP_SW: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_MEMWRITE] = 1'b1;
      end
      OP_BEQ: begin
        c[CTRL_BRANCHEQ] = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALU_SUB;
      end
      OP_BNE: begin
        c[CTRL_BRANCHNE] = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALU_SUB;
      end
      OP_J: begin
        c[CTRL_JUMPCONTROL] = 1'b1;
      end
      OP_JAL: begin
        c[CTRL_JUMPCONTROL] = 1'b1;
        c[CTRL_REGWRITE]    = 1'b1;
        c[CTRL_ALUMEMORPC]  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_pipe_regfile.sv
// ============================================================================
// Module      : regfile_param
// Description : NREGS x NBits register file, two combinational read ports,
//               one synchronous write port, register 0 hard-wired to zero.
//               Macro DECODE_BYPASS_EN: forward same-cycle write data to a
//               matching read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_param
  import decode_pkg::*;
#(
  parameter int NBits = 32,
  parameter int NREGS = 32,
  localparam int RA   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [RA-1:0]    i_waddr,
  input  logic [NBits-1:0] i_wdata,
  input  logic [RA-1:0]    i_raddr1,
  input  logic [RA-1:0]    i_raddr2,
  output logic [NBits-1:0] o_rdata1,
  output logic [NBits-1:0] o_rdata2
);

  logic [NBits-1:0] r_regs [NREGS];
  logic             w_wr_active;
  logic [NBits-1:0] w_rd1;
  logic [NBits-1:0] w_rd2;

  assign w_wr_active = i_we && (i_waddr != '0);

  // Storage: cleared by reset, register 0 never written
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_active) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports: register 0 reads zero, optional write-through forwarding
  always_comb begin
    w_rd1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    w_rd2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
`ifdef DECODE_BYPASS_EN
    if (w_wr_active && (i_waddr == i_raddr1)) w_rd1 = i_wdata;
    if (w_wr_active && (i_waddr == i_raddr2)) w_rd2 = i_wdata;
`endif
  end

  assign o_rdata1 = w_rd1;
  assign o_rdata2 = w_rd2;

endmodule

`default_nettype wire

// File: rtl/decode_stage_pipe.sv
// ============================================================================
// Module      : decode_stage_pipe
// Description : Pipelined instruction-decode stage: control decode, register
//               read, immediate/shamt extension, load-use hazard stall and
//               flush handling, with a registered ID/EX output.
//               Macro DECODE_BYPASS_EN: register-file write forwarding; when
//               undefined a same-cycle read/write collision stalls instead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int NBits = 32,
  parameter int NREGS = 32,
  localparam int RA   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [NBits-1:0]  Instruction,
  input  logic [NBits-1:0]  PC_plus4,
  input  logic              in_RegWrite,
  input  logic [RA-1:0]     in_WriteRegister,
  input  logic [NBits-1:0]  WriteData,
  input  logic              in_ALUMemOrPC,
  input  logic              ex_MemRead,
  input  logic [RA-1:0]     ex_WriteRegister,
  input  logic              flush,
  output logic              Stall,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_Ctrl,
  output logic [RA-1:0]     out_WriteRegister,
  output logic [NBits-1:0]  ReadData1,
  output logic [NBits-1:0]  ReadData2,
  output logic [NBits-1:0]  ImmExtend,
  output logic [NBits-1:0]  ShamtExtend,
  output logic [RA-1:0]     out_Rs,
  output logic [RA-1:0]     out_Rt,
  output logic [NBits-1:0]  out_PC_plus4
);

  localparam logic [RA-1:0] C_LINK_REG = RA'(NREGS - 1);

  logic [RA-1:0]     w_rs;
  logic [RA-1:0]     w_rt;
  logic [RA-1:0]     w_rd;
  logic [CTRL_W-1:0] w_ctrl;
  logic [RA-1:0]     w_dest;
  logic [RA-1:0]     w_wb_addr;
  logic [NBits-1:0]  w_rdata1;
  logic [NBits-1:0]  w_rdata2;
  logic              w_load_use;
  logic              w_wb_conflict;
  logic              w_bubble;

  assign w_rs      = Instruction[21 +: RA];
  assign w_rt      = Instruction[16 +: RA];
  assign w_rd      = Instruction[11 +: RA];
  assign w_ctrl    = control_decode(Instruction[31:26], Instruction[5:0]);
  assign w_dest    = w_ctrl[CTRL_REGDST] ? w_rd : w_rt;
  // Link writes (jal) always land in the top register
  assign w_wb_addr = in_ALUMemOrPC ? C_LINK_REG : in_WriteRegister;

  regfile_param #(
    .NBits (NBits),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_we     (in_RegWrite),
    .i_waddr  (w_wb_addr),
    .i_wdata  (WriteData),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  assign w_load_use = in_valid && ex_MemRead && (ex_WriteRegister != '0) &&
                      ((ex_WriteRegister == w_rs) || (ex_WriteRegister == w_rt));

`ifdef DECODE_BYPASS_EN
  assign w_wb_conflict = 1'b0;
`else
  // Without forwarding the read sees the old value, so wait one cycle for the write
  assign w_wb_conflict = in_RegWrite && (w_wb_addr != '0) &&
                         ((w_wb_addr == w_rs) || (w_wb_addr == w_rt));
`endif

  // Stall is suppressed under reset and when the slot is being flushed anyway
  assign Stall    = reset && !flush && (w_load_use || w_wb_conflict);
  assign w_bubble = flush || !in_valid || Stall;

  // ID/EX register: reset clears, bubble zeroes, otherwise capture the decode
  always_ff @(posedge clk) begin
    if (!reset || w_bubble) begin
      out_valid         <= 1'b0;
      out_Ctrl          <= CTRL_BUBBLE;
      out_WriteRegister <= '0;
      ReadData1         <= '0;
      ReadData2         <= '0;
      ImmExtend         <= '0;
      ShamtExtend       <= '0;
      out_Rs            <= '0;
      out_Rt            <= '0;
      out_PC_plus4      <= '0;
    end else begin
      out_valid         <= 1'b1;
      out_Ctrl          <= w_ctrl;
      out_WriteRegister <= w_dest;
      ReadData1         <= w_rdata1;
      ReadData2         <= w_rdata2;
      ImmExtend         <= {{(NBits-16){Instruction[15]}}, Instruction[15:0]};
      ShamtExtend       <= {{(NBits-5){1'b0}}, Instruction[10:6]};
      out_Rs            <= w_rs;
      out_Rt            <= w_rt;
      out_PC_plus4      <= PC_plus4;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
// ============================================================================
// Module      : tb_decode_stage_pipe
// Description : Self-checking bench for decode_stage_pipe: decode vector
//               table, directed multi-cycle sequences and random stimulus
//               against a behavioural model. Honors DECODE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage_pipe;
  import decode_pkg::*;

  localparam int NB = 32;
  localparam int NR = 32;
  localparam int RA = 5;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [NB-1:0]     Instruction;
  logic [NB-1:0]     PC_plus4;
  logic              in_RegWrite;
  logic [RA-1:0]     in_WriteRegister;
  logic [NB-1:0]     WriteData;
  logic              in_ALUMemOrPC;
  logic              ex_MemRead;
  logic [RA-1:0]     ex_WriteRegister;
  logic              flush;
  logic              Stall;
  logic              out_valid;
  logic [CTRL_W-1:0] out_Ctrl;
  logic [RA-1:0]     out_WriteRegister;
  logic [NB-1:0]     ReadData1;
  logic [NB-1:0]     ReadData2;
  logic [NB-1:0]     ImmExtend;
  logic [NB-1:0]     ShamtExtend;
  logic [RA-1:0]     out_Rs;
  logic [RA-1:0]     out_Rt;
  logic [NB-1:0]     out_PC_plus4;

  decode_stage_pipe #(.NBits(NB), .NREGS(NR)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .Instruction       (Instruction),
    .PC_plus4          (PC_plus4),
    .in_RegWrite       (in_RegWrite),
    .in_WriteRegister  (in_WriteRegister),
    .WriteData         (WriteData),
    .in_ALUMemOrPC     (in_ALUMemOrPC),
    .ex_MemRead        (ex_MemRead),
    .ex_WriteRegister  (ex_WriteRegister),
    .flush             (flush),
    .Stall             (Stall),
    .out_valid         (out_valid),
    .out_Ctrl          (out_Ctrl),
    .out_WriteRegister (out_WriteRegister),
    .ReadData1         (ReadData1),
    .ReadData2         (ReadData2),
    .ImmExtend         (ImmExtend),
    .ShamtExtend       (ShamtExtend),
    .out_Rs            (out_Rs),
    .out_Rt            (out_Rt),
    .out_PC_plus4      (out_PC_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [NB-1:0] m_regs [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Control word built from named flags in package order
  function automatic logic [CTRL_W-1:0] mk(input bit regdst, input bit bne, input bit beq,
                                            input bit [2:0] aluop, input bit alusrc,
                                            input bit regwr, input bit memwr, input bit memrd,
                                            input bit memtoreg, input bit shamt, input bit regpc,
                                            input bit alupc, input bit jump);
    return {regdst, bne, beq, aluop, alusrc, regwr, memwr, memrd, memtoreg,
            shamt, regpc, alupc, jump};
  endfunction

  // Instruction-set table: what each mnemonic should drive
  function automatic logic [CTRL_W-1:0] ref_ctrl(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h08)                           return mk(1,0,0,3'd2,0,0,0,0,0,0,1,0,1); // jr
        if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) return mk(1,0,0,3'd2,0,1,0,0,0,1,0,0,0); // shifts
        return mk(1,0,0,3'd2,0,1,0,0,0,0,0,0,0);                                           // alu R
      end
      6'h08, 6'h09: return mk(0,0,0,3'd0,1,1,0,0,0,0,0,0,0); // addi/addiu
      6'h0A:        return mk(0,0,0,3'd5,1,1,0,0,0,0,0,0,0); // slti
      6'h0C:        return mk(0,0,0,3'd3,1,1,0,0,0,0,0,0,0); // andi
      6'h0D:        return mk(0,0,0,3'd4,1,1,0,0,0,0,0,0,0); // ori
      6'h23:        return mk(0,0,0,3'd0,1,1,0,1,1,0,0,0,0); // lw
      6'h2B:        return mk(0,0,0,3'd0,1,0,1,0,0,0,0,0,0); // sw
      6'h04:        return mk(0,0,1,3'd1,0,0,0,0,0,0,0,0,0); // beq
      6'h05:        return mk(0,1,0,3'd1,0,0,0,0,0,0,0,0,0); // bne
      6'h02:        return mk(0,0,0,3'd0,0,0,0,0,0,0,0,0,1); // j
      6'h03:        return mk(0,0,0,3'd0,0,1,0,0,0,0,0,1,1); // jal
      default:      return '0;
    endcase
  endfunction

  function automatic int wb_target();
    return in_ALUMemOrPC ? NR - 1 : int'(in_WriteRegister);
  endfunction

  function automatic logic [NB-1:0] ref_read(input int a);
    if (a == 0) return '0;
`ifdef DECODE_BYPASS_EN
    if (in_RegWrite && wb_target() != 0 && wb_target() == a) return WriteData;
`endif
    return m_regs[a];
  endfunction

  function automatic bit ref_stall();
    int rs, rt, t;
    bit hz;
    rs = int'(Instruction[25:21]);
    rt = int'(Instruction[20:16]);
    t  = wb_target();
    if (!reset || flush) return 1'b0;
    hz = in_valid && ex_MemRead && ex_WriteRegister != 0 &&
         (int'(ex_WriteRegister) == rs || int'(ex_WriteRegister) == rt);
`ifndef DECODE_BYPASS_EN
    if (in_RegWrite && t != 0 && (t == rs || t == rt)) hz = 1'b1;
`endif
    return hz;
  endfunction

  // One clock: check Stall, predict the ID/EX register and register file, then compare
  task automatic tick();
    bit             s;
    logic           e_valid;
    logic [CTRL_W-1:0] e_ctrl;
    logic [RA-1:0]  e_wr, e_rs, e_rt;
    logic [NB-1:0]  e_rd1, e_rd2, e_imm, e_sh, e_pc;
    #1;
    s = ref_stall();
    chk("Stall", 64'(Stall), 64'(s));
    e_valid = 0; e_ctrl = '0; e_wr = '0; e_rs = '0; e_rt = '0;
    e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_sh = '0; e_pc = '0;
    if (reset && !flush && in_valid && !s) begin
      e_valid = 1'b1;
      e_ctrl  = ref_ctrl(Instruction[31:26], Instruction[5:0]);
      e_rs    = Instruction[25:21];
      e_rt    = Instruction[20:16];
      e_wr    = e_ctrl[CTRL_W-1] ? Instruction[15:11] : Instruction[20:16];
      e_rd1   = ref_read(int'(e_rs));
      e_rd2   = ref_read(int'(e_rt));
      e_imm   = NB'($signed(Instruction[15:0]));
      e_sh    = NB'(Instruction[10:6]);
      e_pc    = PC_plus4;
    end
    if (!reset) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
    end else if (in_RegWrite && wb_target() != 0) begin
      m_regs[wb_target()] = WriteData;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("out_Ctrl", 64'(out_Ctrl), 64'(e_ctrl));
    chk("out_WriteRegister", 64'(out_WriteRegister), 64'(e_wr));
    chk("ReadData1", 64'(ReadData1), 64'(e_rd1));
    chk("ReadData2", 64'(ReadData2), 64'(e_rd2));
    chk("ImmExtend", 64'(ImmExtend), 64'(e_imm));
    chk("ShamtExtend", 64'(ShamtExtend), 64'(e_sh));
    chk("out_Rs", 64'(out_Rs), 64'(e_rs));
    chk("out_Rt", 64'(out_Rt), 64'(e_rt));
    chk("out_PC_plus4", 64'(out_PC_plus4), 64'(e_pc));
  endtask

  task automatic idle_inputs();
    in_valid = 0; Instruction = '0; PC_plus4 = '0; in_RegWrite = 0;
    in_WriteRegister = '0; WriteData = '0; in_ALUMemOrPC = 0;
    ex_MemRead = 0; ex_WriteRegister = '0; flush = 0;
  endtask

  function automatic logic [NB-1:0] rand_instr();
    logic [5:0] ops [12];
    logic [5:0] fns [6];
    logic [5:0] op;
    logic [NB-1:0] w;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    fns = '{6'h20, 6'h22, 6'h00, 6'h02, 6'h08, 6'h2A};
    w = $urandom;
    op = ($urandom_range(0, 15) == 0) ? 6'h3F : ops[$urandom_range(0, 11)];
    w[31:26] = op;
    if (op == 6'h00) w[5:0] = fns[$urandom_range(0, 5)];
    return w;
  endfunction

  typedef struct {
    logic [NB-1:0]     instr;
    logic [CTRL_W-1:0] ctrl;
    logic [RA-1:0]     wr;
    logic [NB-1:0]     imm;
    logic [NB-1:0]     sh;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Decode vectors (hand-assembled words)
    vecs[0] = '{32'h00031100, mk(1,0,0,3'd2,0,1,0,0,0,1,0,0,0), 5'd2, 32'h00001100, 32'd4};  // sll r2,r3,4
    vecs[1] = '{32'h8FA4FFF8, mk(0,0,0,3'd0,1,1,0,1,1,0,0,0,0), 5'd4, 32'hFFFFFFF8, 32'd31}; // lw r4,-8(r29)
    vecs[2] = '{32'hACC5000C, mk(0,0,0,3'd0,1,0,1,0,0,0,0,0,0), 5'd5, 32'h0000000C, 32'd0};  // sw r5,12(r6)
    vecs[3] = '{32'h10220010, mk(0,0,1,3'd1,0,0,0,0,0,0,0,0,0), 5'd2, 32'h00000010, 32'd0};  // beq
    vecs[4] = '{32'h14228000, mk(0,1,0,3'd1,0,0,0,0,0,0,0,0,0), 5'd2, 32'hFFFF8000, 32'd0};  // bne
    vecs[5] = '{32'h0C000100, mk(0,0,0,3'd0,0,1,0,0,0,0,0,1,1), 5'd0, 32'h00000100, 32'd4};  // jal
    vecs[6] = '{32'h03E00008, mk(1,0,0,3'd2,0,0,0,0,0,0,1,0,1), 5'd0, 32'h00000008, 32'd0};  // jr r31
    vecs[7] = '{32'h34078421, mk(0,0,0,3'd4,1,1,0,0,0,0,0,0,0), 5'd7, 32'hFFFF8421, 32'd16}; // ori
    vecs[8] = '{32'hFC000000, 15'd0,                            5'd0, 32'h00000000, 32'd0};  // unknown

    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    idle_inputs();
    reset = 0;
    @(negedge clk);
    tick();

    // Reset state, then read r5
    chk("reset out_valid", 64'(out_valid), 64'd0);
    reset = 1; in_valid = 1; Instruction = 32'h00A00820; // add r1,r5,r0
    #1; chk("reset Stall", 64'(Stall), 64'd0);
    tick();
    chk("r5 after reset", 64'(ReadData1), 64'd0);

    // Decode table
    for (int i = 0; i < 9; i++) begin
      idle_inputs(); in_valid = 1; Instruction = vecs[i].instr; PC_plus4 = 32'h1000 + 32'(4 * i);
      tick();
      chk("vec out_valid", 64'(out_valid), 64'd1);
      chk("vec out_Ctrl", 64'(out_Ctrl), 64'(vecs[i].ctrl));
      chk("vec out_WriteRegister", 64'(out_WriteRegister), 64'(vecs[i].wr));
      chk("vec ImmExtend", 64'(ImmExtend), 64'(vecs[i].imm));
      chk("vec ShamtExtend", 64'(ShamtExtend), 64'(vecs[i].sh));
    end

    // Write r8, then addi r9,r8,-4
    idle_inputs(); in_RegWrite = 1; in_WriteRegister = 5'd8; WriteData = 32'h10;
    tick();
    idle_inputs(); in_valid = 1; Instruction = 32'h2109FFFC;
    tick();
    chk("addi out_valid", 64'(out_valid), 64'd1);
    chk("addi ReadData1", 64'(ReadData1), 64'h10);
    chk("addi ImmExtend", 64'(ImmExtend), 64'hFFFFFFFC);
    chk("addi out_WriteRegister", 64'(out_WriteRegister), 64'd9);

    // Load-use on r8 for add r10,r8,r9
    idle_inputs(); in_valid = 1; Instruction = 32'h01095020; ex_MemRead = 1; ex_WriteRegister = 5'd8;
    #1; chk("load-use Stall", 64'(Stall), 64'd1);
    tick();
    chk("load-use bubble", 64'(out_valid), 64'd0);
    ex_MemRead = 0;
    tick();
    chk("load-use release", 64'(out_valid), 64'd1);

    // Same-cycle write and read of r8
    idle_inputs(); in_valid = 1; Instruction = 32'h01095020;
    in_RegWrite = 1; in_WriteRegister = 5'd8; WriteData = 32'h55;
`ifdef DECODE_BYPASS_EN
    #1; chk("bypass Stall", 64'(Stall), 64'd0);
    tick();
    chk("bypass ReadData1", 64'(ReadData1), 64'h55);
`else
    #1; chk("collide Stall", 64'(Stall), 64'd1);
    tick();
    chk("collide bubble", 64'(out_valid), 64'd0);
    in_RegWrite = 0;
    tick();
    chk("collide ReadData1", 64'(ReadData1), 64'h55);
`endif

    // Link write to r31, read it, then flush over a hazard
    idle_inputs(); in_RegWrite = 1; in_ALUMemOrPC = 1; in_WriteRegister = 5'd3; WriteData = 32'h400;
    tick();
    idle_inputs(); in_valid = 1; Instruction = 32'h03E00820; // add r1,r31,r0
    tick();
    chk("link r31", 64'(ReadData1), 64'h400);
    ex_MemRead = 1; ex_WriteRegister = 5'd31; flush = 1;
    #1; chk("flush Stall", 64'(Stall), 64'd0);
    tick();
    chk("flush bubble", 64'(out_valid), 64'd0);

    // Reset while stalled
    flush = 0;
    #1; chk("pre-reset Stall", 64'(Stall), 64'd1);
    reset = 0;
    #1; chk("reset kills Stall", 64'(Stall), 64'd0);
    tick();
    chk("reset-mid out_valid", 64'(out_valid), 64'd0);
    chk("reset-mid ImmExtend", 64'(ImmExtend), 64'd0);
    reset = 1; ex_MemRead = 0;
    tick();
    chk("r31 cleared", 64'(ReadData1), 64'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset            = ($urandom_range(0, 39) != 0);
      flush            = ($urandom_range(0, 9) == 0);
      in_valid         = ($urandom_range(0, 4) != 0);
      Instruction      = rand_instr();
      PC_plus4         = $urandom;
      in_RegWrite      = $urandom_range(0, 1) == 1;
      in_ALUMemOrPC    = ($urandom_range(0, 7) == 0);
      in_WriteRegister = ($urandom_range(0, 2) == 0) ? Instruction[25:21] : 5'($urandom);
      WriteData        = $urandom;
      ex_MemRead       = ($urandom_range(0, 2) == 0);
      ex_WriteRegister = ($urandom_range(0, 1) == 0) ? Instruction[20:16] : 5'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
